// File: rtl/fir_resampler_decim.sv
// Decimator back end for an interpolating resampler: keeps every ratio-th valid
// multi-channel sample and queues it in a first-word-fall-through output buffer.
module fir_resampler_decim #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int DEC_MAX     = 32,
    parameter int DEC_DEFAULT = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEC_WIDTH   = $clog2(DEC_MAX + 1),
    parameter int LVL_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
    input  logic                           data_val_i,
    input  logic [DEC_WIDTH-1:0]           dec_ratio_i,
    input  logic                           dec_load_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                           data_val_o,
    input  logic                           data_rdy_i,
    output logic [LVL_WIDTH-1:0]           fifo_level_o,
    output logic                           ovf_o,
    input  logic                           ovf_clr_i
);

    localparam int WORD_W = CHANNELS * DATA_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DEC_WIDTH-1:0] ratio_q, ratio_d;
    logic [DEC_WIDTH-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0] level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]    mem_d [FIFO_DEPTH];

    logic keep, empty, full, xfer, wr_en, drop;

    always_comb begin
        ratio_d = ratio_q;
        cnt_d   = cnt_q;
        // A load wins over a coincident sample: the sample is neither kept nor counted.
        keep    = data_val_i && !dec_load_i && (cnt_q == ratio_q - DEC_WIDTH'(1));
        if (dec_load_i) begin
            if (dec_ratio_i == '0) begin
                ratio_d = DEC_WIDTH'(1);
            end else if (dec_ratio_i > DEC_WIDTH'(DEC_MAX)) begin
                ratio_d = DEC_WIDTH'(DEC_MAX);
            end else begin
                ratio_d = dec_ratio_i;
            end
            cnt_d = '0;
        end else if (data_val_i) begin
            cnt_d = keep ? '0 : cnt_q + DEC_WIDTH'(1);
        end
    end

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LVL_WIDTH'(FIFO_DEPTH));
        xfer  = !empty && data_rdy_i;
        // When full, a same-cycle read frees the slot the new word lands in.
        wr_en = keep && (!full || xfer);
        drop  = keep && full && !xfer;

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(xfer);
        level_d  = level_q + LVL_WIDTH'(wr_en) - LVL_WIDTH'(xfer);
        ovf_d    = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ratio_q  <= DEC_WIDTH'(DEC_DEFAULT);
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ratio_q  <= ratio_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; the level gates everything visible.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign data_o       = empty ? '0 : mem_q[rd_ptr_q];
    assign data_val_o   = !empty;
    assign fifo_level_o = level_q;
    assign ovf_o        = ovf_q;

endmodule
